// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch hazard, bypass select and taken/flush control
module branch_hazard_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wa,
  input  logic             id_is_load,
  input  logic             cmp_eq,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             branch_taken,
  output logic             flush_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // In-flight destination tracking; WB keeps no load bit since a WB
  // producer is always forwardable.
  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_wa, mem_wa, wb_wa;
  logic       ex_load, mem_load;

  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic is_branch;

  // Register $0 is hard-wired, so an entry targeting it never matches.
  function automatic logic hit(input logic use_bit, input logic v,
                               input logic [4:0] wa, input logic [4:0] src);
    return use_bit & v & (wa != 5'd0) & (wa == src);
  endfunction

  // Bypass choice: MEM ALU result is the youngest forwardable value, then WB.
  function automatic logic [1:0] fwd_pick(input logic m_hit, input logic m_load,
                                          input logic w_hit);
    if (m_hit && !m_load) return 2'd1;
    else if (w_hit)       return 2'd2;
    else                  return 2'd0;
  endfunction

  // Source-versus-stage match decode
  always_comb begin
    rs_ex  = hit(id_use_rs, ex_valid,  ex_wa,  id_rs);
    rt_ex  = hit(id_use_rt, ex_valid,  ex_wa,  id_rt);
    rs_mem = hit(id_use_rs, mem_valid, mem_wa, id_rs);
    rt_mem = hit(id_use_rt, mem_valid, mem_wa, id_rt);
    rs_wb  = hit(id_use_rs, wb_valid,  wb_wa,  id_rs);
    rt_wb  = hit(id_use_rt, wb_valid,  wb_wa,  id_rt);
  end

  // Stall, bypass and taken decisions; all forced low while reset is held
  always_comb begin
    is_branch    = rst_n & id_valid & id_is_branch;
    stall        = 1'b0;
    fwd_rs_sel   = 2'd0;
    fwd_rt_sel   = 2'd0;
    branch_taken = 1'b0;
    if (rst_n && id_valid) begin
      if (id_is_branch)
        // The comparator sits in ID, so an EX producer of any kind and a
        // MEM load are both still too late to bypass.
        stall = rs_ex | rt_ex | (mem_load & (rs_mem | rt_mem));
      else
        stall = ex_load & (rs_ex | rt_ex);
    end
    if (is_branch) begin
      fwd_rs_sel   = fwd_pick(rs_mem, mem_load, rs_wb);
      fwd_rt_sel   = fwd_pick(rt_mem, mem_load, rt_wb);
      branch_taken = ~stall & (id_is_bne ? ~cmp_eq : cmp_eq);
    end
    flush_if = branch_taken & (DELAY_SLOT == 0);
  end

  // Advance the scoreboard; a stalled ID instruction enters EX as a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_wa     <= 5'd0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_wa    <= 5'd0;
      mem_load  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wa     <= 5'd0;
    end else begin
      wb_valid  <= mem_valid;
      wb_wa     <= mem_wa;
      mem_valid <= ex_valid;
      mem_wa    <= ex_wa;
      mem_load  <= ex_load;
      ex_valid  <= id_valid & id_wr_en & ~stall;
      ex_wa     <= id_wa;
      ex_load   <= id_is_load;
    end
  end

  // Saturating stall and taken statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Pipeline controller for the ID-stage branch resolution path of the five-stage MIPS core. It tracks the destinations of in-flight instructions in EX/MEM/WB and decides per cycle whether the ID instruction must stall and which bypass feeds the branch comparator. It qualifies the beq/bne taken decision (condition AND branch AND not stalled) into the PC-select and IF/ID flush controls, and keeps saturating stall/taken statistics.

## Interface
- DELAY_SLOT, 1, 1: branch delay slot executes, flush_if never asserts; 0: flush_if asserts with branch_taken
- CNT_W, 16, width of statistics counters
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_is_branch  in  1  ID instruction is beq or bne
- id_is_bne  in  1  1 = bne, 0 = beq (valid with id_is_branch)
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_wr_en  in  1  ID instruction writes the register file
- id_wa  in  5  ID destination register
- id_is_load  in  1  ID instruction is lw
- cmp_eq  in  1  ID comparator result on forwarded operands
- stall  out  1  freeze PC and IF/ID, inject bubble into EX
- fwd_rs_sel, fwd_rt_sel  out  2 each  comparator source: 0 regfile, 1 MEM ALU result, 2 WB data
- branch_taken  out  1  select branch target for PC
- flush_if  out  1  clear IF/ID on the next edge
- stall_cnt, taken_cnt  out  CNT_W each  saturating event counts

## Operation
- Scoreboard: three entries (EX, MEM, WB), each {valid, wa[4:0], load}. An entry with wa = 0 is treated as invalid for all matching.
- Each edge: WB<-MEM, MEM<-EX. EX<-{id_valid & id_wr_en & ~stall, id_wa, id_is_load}. When stalled, EX receives a bubble.
- A source "matches" a stage when its use bit is set, the stage is valid, and wa equals the source (nonzero).
- Stall for a branch in ID (any matching source):
  - EX match (ALU or load): stall.
  - MEM match with load = 1: stall.
- Stall for a non-branch in ID: EX match with load = 1 (load-use).
- Forward select per source, evaluated in priority order MEM, WB, regfile:
  - MEM match with load = 0: 1.
  - Else WB match: 2.
  - Else 0.
  - EX is never a forward source.
- Outputs for ID instructions that are not branches are 0.
- branch_taken = id_valid & id_is_branch & ~stall & (id_is_bne ? ~cmp_eq : cmp_eq).
- flush_if = branch_taken & (DELAY_SLOT == 0).
- stall_cnt increments on each cycle with stall = 1. taken_cnt increments on each cycle with branch_taken = 1. Both saturate at 2^CNT_W-1 and hold.
- id_valid = 0: stall, branch_taken and flush_if are 0, and no entry is pushed.

## Timing
- stall, fwd_*_sel, branch_taken and flush_if are combinational from ID inputs, the scoreboard state and cmp_eq. They settle in the same cycle and have no register latency.
- Scoreboard and counters update on the rising clk edge.
- Stall durations for a branch:
  - Directly after an ALU producer: 1 cycle, then fwd = 1.
  - Directly after a load: 2 cycles, then fwd = 2.
  - Load two instructions ahead: 1 cycle, then fwd = 2.
- Load-use for a non-branch: 1 cycle.
- A stall never exceeds 2 consecutive cycles for one ID instruction.
- Reset (asynchronous, any time, including mid-stall):
  - All scoreboard entries become invalid, and both counters go to 0.
  - stall, branch_taken and flush_if are 0 immediately while rst_n = 0, regardless of inputs. fwd selects are 0.
- Release of rst_n is synchronous to the next edge. No state change occurs on the release edge itself beyond normal sampling.
- Same source matched in MEM and WB: MEM wins, since it is the younger producer.
- Both rs and rt in hazard: stall length is the maximum of the two.

## Test plan
- addu $3 then beq $3,$0 with cmp_eq=1 -> stall=1 for 1 cycle, next cycle fwd_rs_sel=1, branch_taken=1, taken_cnt=1.
- lw $4 then bne $4,$5 with cmp_eq=0 -> stall=1 for 2 cycles, then fwd_rs_sel=2, branch_taken=1, stall_cnt=2.
- lw $5 then addu $6,$5,$7 -> stall=1 for exactly 1 cycle. Then an EX bubble appears: EX entry invalid, MEM entry = $5 load.
- addu $0 then beq $0,$0 -> stall=0, fwd_rs_sel=0, branch_taken=1. Writes to $0 never create hazards.
- DELAY_SLOT=0, beq taken with no hazard -> branch_taken=1 and flush_if=1 in the same cycle. With DELAY_SLOT=1 the same stimulus gives flush_if=0.
- Assert rst_n=0 during the second cycle of a load-branch stall -> stall drops to 0 immediately and counters read 0. After release, the branch with regfile operands resolves with no stall.
